serial_word_assembler: RTL and testbench
========================================

// Module: serial_word_assembler
// PURPOSE
//   Upstream feeder for the 4-bit PIPO register stage. Collects a framed serial
//   bit stream MSB-first and assembles it into WIDTH-bit words.
//   Presents each word on a valid/ready parallel port so the PIPO stage loads
//   whole words. The serial side cannot be stalled; words that find the output
//   holding register occupied are dropped and flagged.
// PARAMETERS
//   WIDTH   4   data bits per word (>=2)
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-low reset
//   sin        in   1      serial data bit
//   sin_valid  in   1      sin sampled this cycle
//   sin_start  in   1      qualifies sin_valid: this bit is bit 0 (MSB) of a new frame
//   out_data   out  WIDTH  assembled word, MSB = first bit received
//   out_valid  out  1      out_data holds an undelivered word
//   out_ready  in   1      downstream accepts out_data this cycle
//   out_perr   out  1      parity error flag travelling with out_data
//   overrun    out  1      1-cycle pulse: completed word dropped
// BEHAVIOUR
//   - Reset (rst=0, async): state=IDLE, shift reg=0, bit count=0, out_data=0,
//     out_valid=0, out_perr=0, overrun=0. Deassertion is synchronous to clk.
//   - States: IDLE, SHIFT, PAR (PAR exists only with the macro).
//   - IDLE: sin_valid && sin_start -> load bit, cnt=1, go SHIFT. Other bits ignored.
//   - SHIFT: each sin_valid shifts sreg <= {sreg[WIDTH-2:0], sin} and increments cnt.
//     Cycles without sin_valid hold state (gaps allowed).
//   - sin_valid && sin_start in any state restarts the frame: partial bits are
//     discarded and this bit becomes bit 0. Never an error.
//   - Word complete on the edge that samples bit WIDTH-1. Without the macro:
//     deliver at that edge, go IDLE.
//   - Deliver: if !out_valid || out_ready (same-cycle drain), load out_data and
//     out_perr, set out_valid at that edge (0 extra latency).
//     Otherwise the word is dropped and overrun pulses for 1 cycle.
//     out_data is unchanged on a drop.
//   - Handshake: transfer when out_valid && out_ready. out_valid clears next
//     edge unless a new word loads on the same edge. out_data and out_perr
//     stay stable while out_valid && !out_ready.
//   - A frame of WIDTH=1 is never possible; cnt width is $clog2(WIDTH+1).
//   - Mid-frame reset: partial word lost, no overrun.
// CONFIGURATION
//   SWA_PARITY_CHECK_EN defined:
//     - After WIDTH data bits the FSM enters PAR. The next sin_valid bit is even
//       parity; out_perr = ^{data,pbit}.
//     - Delivery happens at the parity-bit edge. sin_start in PAR restarts the
//       frame and drops the word.
//   Not defined:
//     - No PAR state; out_perr is tied 0.
// STRUCTURE
//   - Package swa_pkg: state enum typedef (IDLE, SHIFT, PAR) and function
//     swa_cnt_w(WIDTH).
//   - Sub-module swa_hold_reg: output holding register with valid/ready and
//     load/drop decision. Parameterized on WIDTH+1 bits (data + perr).
//     Outputs its overrun pulse.
//   - Top contains the FSM, shift register and bit counter.
// TESTING
//   1. Reset: rst=0 mid-run -> all outputs 0 immediately, without a clk edge.
//   2. Frame 1,0,1,1 with start on the first bit, out_ready=1 ->
//      out_data=4'b1011, out_valid at the 4th-bit edge, held 1 cycle.
//   3. Back-to-back frames 1100 then 0011 with out_ready=0 until the second
//      completes -> out_data=1100 kept, overrun pulse once, 0011 lost.
//   4. Frame 1010 with sin_valid gaps of 0-3 cycles between bits ->
//      out_data=1010.
//   5. Restart: bits 1,1 then sin_start with 0,0,0,1 -> out_data=0001, no overrun.
//   6. With SWA_PARITY_CHECK_EN: data 1011 + pbit 1 -> out_perr=0.
//      Data 1011 + pbit 0 -> out_perr=1.

Source files
------------

// File: rtl/swa_pkg.sv
// swa_pkg: shared state encoding and counter sizing for serial_word_assembler
package swa_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} swa_state_e;
  function automatic int swa_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/swa_hold_reg.sv
// swa_hold_reg: valid/ready output holding register that drops words arriving while occupied
module swa_hold_reg #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_v,
  input  logic [W-1:0] load_d,
  input  logic         out_ready,
  output logic [W-1:0] q,
  output logic         valid,
  output logic         overrun
);
  logic accept;
  assign accept = !valid || out_ready;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q       <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= load_v && !accept;
      if (load_v && accept) begin
        q     <= load_d;
        valid <= 1'b1;
      end else if (out_ready) begin
        valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/serial_word_assembler.sv
// serial_word_assembler: MSB-first framed serial to WIDTH-bit word converter with a valid/ready port.
// Define SWA_PARITY_CHECK_EN to expect a trailing even-parity bit per frame and report it on out_perr.
module serial_word_assembler
  import swa_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_perr,
  output logic             overrun
);
  localparam int CW = swa_cnt_w(WIDTH);
  swa_state_e       state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n, shifted, word_d;
  logic [CW-1:0]    cnt, cnt_n;
  logic             start, last, word_v, word_p;
  logic [WIDTH:0]   hold_q;
  assign start   = sin_valid && sin_start;
  assign shifted = {sreg[WIDTH-2:0], sin};
  assign last    = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      cnt   <= cnt_n;
    end
  end
  // a start bit always wins, so a restart in SHIFT or PAR silently discards the frame
  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;
    word_v  = 1'b0;
    word_d  = shifted;
    word_p  = 1'b0;
    if (start) begin
      state_n = SHIFT;
      sreg_n  = {{(WIDTH-1){1'b0}}, sin};
      cnt_n   = CW'(1);
    end else if (sin_valid && state == SHIFT) begin
      sreg_n = shifted;
      cnt_n  = cnt + CW'(1);
      if (last) begin
`ifdef SWA_PARITY_CHECK_EN
        state_n = PAR;
`else
        state_n = IDLE;
        cnt_n   = '0;
        word_v  = 1'b1;
`endif
      end
    end
`ifdef SWA_PARITY_CHECK_EN
    else if (sin_valid && state == PAR) begin
      state_n = IDLE;
      cnt_n   = '0;
      word_v  = 1'b1;
      word_d  = sreg;
      word_p  = ^{sreg, sin};
    end
`endif
  end
  swa_hold_reg #(.W(WIDTH + 1)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load_v    (word_v),
    .load_d    ({word_d, word_p}),
    .out_ready (out_ready),
    .q         (hold_q),
    .valid     (out_valid),
    .overrun   (overrun)
  );
  assign out_data = hold_q[WIDTH:1];
  assign out_perr = hold_q[0];
endmodule

// File: tb/tb_serial_word_assembler.sv
// tb_serial_word_assembler: directed stimulus with a queue scoreboard checked by a handshake monitor
module tb_serial_word_assembler;
  logic       clk = 1'b0;
  logic       rst, sin, sin_valid, sin_start, out_ready;
  logic [3:0] out_data;
  logic       out_valid, out_perr, overrun;
  logic [4:0] sb[$];
  int         tests = 0, fails = 0, ovr_cnt = 0;

  serial_word_assembler #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .sin_valid (sin_valid),
    .sin_start (sin_start),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_perr  (out_perr),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && overrun === 1'b1) ovr_cnt++;
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_word", {27'd0, out_data, out_perr}, 32'h0);
      else chk("word", {27'd0, out_data, out_perr}, {27'd0, sb.pop_front()});
    end
  end

  task automatic send_bit(input logic b, input logic st);
    sin = b;
    sin_valid = 1'b1;
    sin_start = st;
    @(posedge clk);
    #1;
    sin_valid = 1'b0;
    sin_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    if (n > 0) #1;
  endtask

  task automatic send_word(input logic [3:0] d, input bit push);
    if (push) sb.push_back({d, 1'b0});
    for (int i = 3; i >= 0; i--) send_bit(d[i], i == 3);
`ifdef SWA_PARITY_CHECK_EN
    send_bit(^d, 1'b0);
`endif
  endtask

  initial begin
    rst = 1'b0; sin = 1'b0; sin_valid = 1'b0; sin_start = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_data", {28'd0, out_data}, 32'h0);
    chk("rst_valid", {31'd0, out_valid}, 32'h0);
    chk("rst_perr", {31'd0, out_perr}, 32'h0);
    chk("rst_overrun", {31'd0, overrun}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);
    // single frame, valid on the completing edge, held one cycle
    send_word(4'b1011, 1'b1);
    chk("t2_valid_rise", {31'd0, out_valid}, 32'h1);
    chk("t2_data", {28'd0, out_data}, 32'hb);
    idle(1);
    chk("t2_valid_fall", {31'd0, out_valid}, 32'h0);
    // second word finds the holding register occupied and is dropped
    out_ready = 1'b0;
    send_word(4'b1100, 1'b1);
    send_word(4'b0011, 1'b0);
    chk("t3_overrun_pulse", {31'd0, overrun}, 32'h1);
    chk("t3_data_kept", {28'd0, out_data}, 32'hc);
    idle(1);
    chk("t3_overrun_clear", {31'd0, overrun}, 32'h0);
    chk("t3_valid_held", {31'd0, out_valid}, 32'h1);
    out_ready = 1'b1;
    idle(2);
    chk("t3_ovr_total", ovr_cnt, 1);
    // gaps between serial bits
    sb.push_back({4'b1010, 1'b0});
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    idle(3);
    send_bit(1'b1, 1'b0);
    idle(1);
    send_bit(1'b0, 1'b0);
`ifdef SWA_PARITY_CHECK_EN
    idle(2);
    send_bit(1'b0, 1'b0);
`endif
    idle(2);
    // restart mid-frame discards the partial bits without an overrun
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_word(4'b0001, 1'b1);
    idle(2);
    chk("t5_ovr_total", ovr_cnt, 1);
`ifdef SWA_PARITY_CHECK_EN
    sb.push_back({4'b1011, 1'b0});
    for (int i = 3; i >= 0; i--) send_bit(4'b1011 >> i, i == 3);
    send_bit(1'b1, 1'b0);
    idle(2);
    sb.push_back({4'b1011, 1'b1});
    for (int i = 3; i >= 0; i--) send_bit(4'b1011 >> i, i == 3);
    send_bit(1'b0, 1'b0);
    idle(2);
`endif
    // asynchronous reset while a word is held
    out_ready = 1'b0;
    send_word(4'b0110, 1'b0);
    chk("t1_valid_before_rst", {31'd0, out_valid}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("t1_data", {28'd0, out_data}, 32'h0);
    chk("t1_valid", {31'd0, out_valid}, 32'h0);
    chk("t1_perr", {31'd0, out_perr}, 32'h0);
    chk("t1_overrun", {31'd0, overrun}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    idle(2);
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    chk("sb_drained", sb.size(), 0);
    chk("final_ovr_total", ovr_cnt, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
